prold_loader: RTL and testbench
===============================

# prold_loader

Program loader that drives the fetch unit's prold (program-load) interface. It sits between the UART byte receiver and `fetch`. It collects a little-endian word count followed by that many little-endian 32-bit instructions, and emits one packed `prold_info` write per instruction. When the last write has drained into instruction memory it drops prold mode, handshakes an acknowledge byte to the UART transmitter, and leaves the core in run mode.

## Interface
Parameters:
- `LEN_WORD`, `` `LEN_WORD `` (32): width of PC, data and count fields.
- `BASE_PC`, 0: PC of the first loaded instruction.
- `MEM_WORDS`, `2**(`LEN_MEMISTR_ADDR+`LOG_FETCH_PARA)`: instruction memory capacity in words.
- `DRAIN_CYCLES`, 2: idle cycles after the last write before prold mode is released.
- `ACK_BYTE`, 8'hAA: byte sent on completion.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid this cycle. No backpressure.
- `rx_data`  in  8  received byte.
- `prold_info`  out  `` `LEN_PROLD_INFO ``  packed {mode, order, pc[31:0], data[31:0]}; mode is the MSB.
- `tx_valid`  out  1  acknowledge byte valid; held until accepted.
- `tx_ready`  in  1  transmitter accepts the byte when `tx_valid & tx_ready`.
- `tx_data`  out  8  acknowledge byte.
- `load_done`  out  1  one-cycle pulse when prold mode is released.
- `load_err`  out  1  sticky; the header count exceeds `MEM_WORDS`.

## Operation
- States:
  - HDR: collect 4 count bytes.
  - DATA: collect instruction bytes.
  - DRAIN: wait `DRAIN_CYCLES`.
  - ACK: present the acknowledge byte.
  - RUN: load complete.
  - ERR: count rejected.
- Reset: all outputs go to their reset values and the state goes to HDR. Reset values:
  - mode = 1; order = 0; pc = 0; data = 0.
  - `tx_valid` = 0; `tx_data` = 0.
  - `load_done` = 0; `load_err` = 0.
  - Internal byte index = 0, word counter = 0.
- HDR: each accepted byte shifts into the count register. Byte 0 is the LSB.
  - After the 4th byte, the next state is decided from count N:
    - N > `MEM_WORDS` → ERR.
    - N = 0 → DRAIN.
    - otherwise → DATA.
- DATA: bytes are assembled little-endian into a 32-bit word.
  - On the 4th byte of word k, the next cycle carries order = 1, pc = `BASE_PC` + 4·k, data = the assembled word.
  - order is exactly one cycle wide. pc and data hold their last values while order = 0.
  - After word N-1 is emitted → DRAIN.
- DRAIN: counts `DRAIN_CYCLES` cycles with mode = 1 and order = 0. This covers the fetch unit's one-cycle registered write path plus one cycle of margin. Then → ACK.
- ACK:
  - mode goes to 0; `load_done` pulses for 1 cycle on entry.
  - `tx_valid` = 1 and `tx_data` = `ACK_BYTE`, both held until `tx_ready`. Then → RUN.
- RUN: mode = 0 and `tx_valid` = 0. `rx_valid` is ignored. Only `rst` leaves this state.
- ERR: `load_err` = 1 and mode stays 1. No writes, no ack. `rx_valid` is ignored until `rst`.
- Arithmetic:
  - The word counter is `$clog2(MEM_WORDS)+1` bits wide.
  - pc is computed as `BASE_PC + (k << 2)`, truncated to `LEN_WORD`.
  - The count compare uses the full 32 bits.
- Boundary conditions:
  - A count of exactly `MEM_WORDS` is accepted.
  - A byte arriving in the same cycle as the order output is accepted normally; the assembly register is separate from the output register.
  - `rst` asserted mid-word or mid-drain discards partial state. The next byte is treated as count byte 0.

## Timing
- A byte accepted at edge t updates internal state at t.
- For the 4th byte of a word accepted at edge t, `prold_info.order` = 1 during cycle t+1.
- `rx_valid` may be asserted every cycle; full throughput is one word per 4 cycles.
- Last order at cycle c → mode = 0 and `load_done` = 1 at cycle c+1+`DRAIN_CYCLES`. `tx_valid` rises in the same cycle.
- N = 0: last header byte at edge t → DRAIN from t+1; mode = 0 at t+1+`DRAIN_CYCLES`.
- Every output is driven from a register; there is no combinational path from `rx_*` or `tx_ready` to any output.

## Structure
- Shared package/include:
  - `` `LEN_PROLD_INFO `` (= 2+2·`` `LEN_WORD ``).
  - The field order of `prold_info`.
  - The state encoding constants.
  - `ACK_BYTE`.
- Sub-module `pack_prold_info`: the combinational inverse of `unpack_prold_info` (mode, order, pc, data → `prold_info`). Both must use the same field order from the shared include.
- FSM, byte assembler, word counter and drain counter stay in `prold_loader`.

## Test plan
- Count 2, words 32'h00000013 and 32'hDEADBEEF, bytes back-to-back → two order pulses 4 cycles apart with pc 0 then 4. Mode falls 1+2 cycles after the second pulse; tx byte = 8'hAA.
- Count 0 → no order pulse. Mode falls 3 cycles after the 4th header byte; `load_done` pulses once.
- Count = `MEM_WORDS`+1 → `load_err` = 1, mode stays 1, `tx_valid` stays 0, further bytes are ignored.
- Bytes spaced by random 0–5 idle cycles, count 3 → pc sequence 0, 4, 8 with data matching the input byte order.
- Hold `tx_ready` low for 10 cycles in ACK → `tx_valid` and `tx_data` are held stable and mode stays 0. One handshake occurs, then `tx_valid` = 0.
- Assert `rst` after 6 bytes of a load, then send a fresh count-1 load → exactly one order at pc 0 with the new word, and all outputs at reset values during `rst`.

Source files
------------

// File: rtl/prold_loader_pkg.sv
// Shared definitions for the program loader: prold_info layout, FSM states, defaults.
// pack_prold_info and unpack_prold_info both derive field order from prold_info_t.
package prold_loader_pkg;

  localparam int PL_LEN_WORD         = 32;
  localparam int PL_LEN_MEMISTR_ADDR = 8;
  localparam int PL_LOG_FETCH_PARA   = 1;
  localparam int PL_MEM_WORDS        = 2 ** (PL_LEN_MEMISTR_ADDR + PL_LOG_FETCH_PARA);
  localparam int PL_LEN_PROLD_INFO   = 2 + 2 * PL_LEN_WORD;
  localparam logic [7:0] PL_ACK_BYTE = 8'hAA;

  // mode is the MSB; data occupies the low word
  typedef struct packed {
    logic                   mode;
    logic                   order;
    logic [PL_LEN_WORD-1:0] pc;
    logic [PL_LEN_WORD-1:0] data;
  } prold_info_t;

  typedef enum logic [2:0] {
    ST_HDR   = 3'd0,
    ST_DATA  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_ACK   = 3'd3,
    ST_RUN   = 3'd4,
    ST_ERR   = 3'd5
  } state_e;

  function automatic prold_info_t unpack_prold_info(input logic [PL_LEN_PROLD_INFO-1:0] v);
    return prold_info_t'(v);
  endfunction

endpackage

// File: rtl/prold_loader_pack.sv
// Combinational packer for the fetch unit's prold_info bus; inverse of unpack_prold_info.
module pack_prold_info
  import prold_loader_pkg::*;
(
  input  logic                         mode,
  input  logic                         order,
  input  logic [PL_LEN_WORD-1:0]       pc,
  input  logic [PL_LEN_WORD-1:0]       data,
  output logic [PL_LEN_PROLD_INFO-1:0] prold_info
);

  prold_info_t info;

  always_comb begin
    info       = '0;
    info.mode  = mode;
    info.order = order;
    info.pc    = pc;
    info.data  = data;
  end

  assign prold_info = info;

endmodule

// File: rtl/prold_loader.sv
// Loads a little-endian word count and that many 32-bit words from the UART into fetch,
// then releases prold mode after a drain period and handshakes an acknowledge byte.
module prold_loader
  import prold_loader_pkg::*;
#(
  parameter int              LEN_WORD     = PL_LEN_WORD,
  parameter logic [LEN_WORD-1:0] BASE_PC  = '0,
  parameter int              MEM_WORDS    = PL_MEM_WORDS,
  parameter int              DRAIN_CYCLES = 2,
  parameter logic [7:0]      ACK_BYTE     = PL_ACK_BYTE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx_valid,
  input  logic [7:0]                rx_data,
  output logic [2+2*LEN_WORD-1:0]   prold_info,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic [7:0]                tx_data,
  output logic                      load_done,
  output logic                      load_err
);

  localparam int CW = $clog2(MEM_WORDS) + 1;
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_e              state, state_n;
  logic [1:0]          byte_idx;
  logic [31:0]         count_q;
  logic [31:0]         asm_q;
  logic [CW-1:0]       word_cnt;
  logic [DW-1:0]       drain_cnt;
  logic                mode_q, order_q, tx_valid_q, done_q, err_q;
  logic [LEN_WORD-1:0] pc_q, data_q;
  logic [7:0]          tx_data_q;

  logic [31:0] count_n, word_n;
  logic        last_byte, last_word;

  assign count_n   = {rx_data, count_q[31:8]};
  assign word_n    = {rx_data, asm_q[31:8]};
  assign last_byte = (byte_idx == 2'd3);
  assign last_word = ((32'(word_cnt) + 32'd1) == count_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_HDR;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_HDR: begin
        if (rx_valid && last_byte) begin
          if (count_n > 32'(MEM_WORDS)) state_n = ST_ERR;
          else if (count_n == 32'd0)    state_n = ST_DRAIN;
          else                          state_n = ST_DATA;
        end
      end
      ST_DATA:  if (rx_valid && last_byte && last_word) state_n = ST_DRAIN;
      // the write cycle itself is not counted as drain time
      ST_DRAIN: if (!order_q && drain_cnt == DW'(DRAIN_CYCLES - 1)) state_n = ST_ACK;
      ST_ACK:   if (tx_ready) state_n = ST_RUN;
      default:  state_n = state;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx   <= '0;
      count_q    <= '0;
      asm_q      <= '0;
      word_cnt   <= '0;
      drain_cnt  <= '0;
      mode_q     <= 1'b1;
      order_q    <= 1'b0;
      pc_q       <= '0;
      data_q     <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      order_q <= 1'b0;
      done_q  <= 1'b0;
      case (state)
        ST_HDR: begin
          if (rx_valid) begin
            count_q  <= count_n;
            byte_idx <= byte_idx + 2'd1;
          end
        end
        ST_DATA: begin
          if (rx_valid) begin
            asm_q    <= word_n;
            byte_idx <= byte_idx + 2'd1;
            if (last_byte) begin
              order_q  <= 1'b1;
              pc_q     <= BASE_PC + (LEN_WORD'(word_cnt) << 2);
              data_q   <= LEN_WORD'(word_n);
              word_cnt <= word_cnt + CW'(1);
            end
          end
        end
        ST_DRAIN: if (!order_q) drain_cnt <= drain_cnt + DW'(1);
        default: ;
      endcase
      if (state == ST_DRAIN && state_n == ST_ACK) begin
        mode_q     <= 1'b0;
        done_q     <= 1'b1;
        tx_valid_q <= 1'b1;
        tx_data_q  <= ACK_BYTE;
      end
      if (state == ST_ACK && state_n == ST_RUN) tx_valid_q <= 1'b0;
      if (state_n == ST_ERR) err_q <= 1'b1;
    end
  end

  pack_prold_info u_pack (
    .mode       (mode_q),
    .order      (order_q),
    .pc         (pc_q),
    .data       (data_q),
    .prold_info (prold_info)
  );

  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign load_done = done_q;
  assign load_err  = err_q;

endmodule

// File: tb/tb_prold_loader.sv
// Randomized scoreboard bench for prold_loader: expected writes/acks queued by stimulus, popped by a monitor.
module tb_prold_loader;
  import prold_loader_pkg::*;

  localparam int MEMW  = 16;
  localparam int DRAIN = 2;

  logic clk = 1'b0;
  logic rst, rx_valid, tx_ready, tx_valid, load_done, load_err;
  logic [7:0] rx_data, tx_data;
  logic [PL_LEN_PROLD_INFO-1:0] prold_info;
  prold_info_t pi;

  prold_loader #(.MEM_WORDS(MEMW), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .prold_info(prold_info), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .load_done(load_done), .load_err(load_err)
  );

  assign pi = unpack_prold_info(prold_info);
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct packed { logic [31:0] pc; logic [31:0] data; } wr_t;
  wr_t        exp_wr[$];
  logic [7:0] exp_ack[$];
  logic [31:0] wbuf[MEMW];
  int  passes = 0, total = 0;
  int  ref_cyc = -100, prev_ord = 0, n_ord = 0, n_done = 0, n_hs = 0;
  bit  b2b = 0;
  wr_t mon_e;
  logic [7:0] mon_a;

  task automatic chk(input string name, input bit ok, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (ok) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: all outputs are stable between the negedge and the next posedge
  always @(negedge clk) begin
    if (!rst) begin
      if (pi.order) begin
        if (exp_wr.size() == 0) chk("unexpected_order", 1'b0, 128'({pi.pc, pi.data}), 128'(0));
        else begin
          mon_e = exp_wr.pop_front();
          chk("write", pi.mode && pi.pc == mon_e.pc && pi.data == mon_e.data,
              128'({pi.mode, pi.pc, pi.data}), 128'({1'b1, mon_e.pc, mon_e.data}));
        end
        if (b2b && n_ord > 0) chk("b2b_spacing", (cyc - prev_ord) == 4, 128'(cyc - prev_ord), 128'(4));
        prev_ord = cyc;
        ref_cyc  = cyc;
        n_ord++;
      end
      if (load_done) begin
        n_done++;
        chk("done_timing", (cyc - ref_cyc) == 1 + DRAIN && !pi.mode && tx_valid && tx_data == PL_ACK_BYTE,
            128'({tx_valid, pi.mode, 32'(cyc - ref_cyc)}), 128'({1'b1, 1'b0, 32'(1 + DRAIN)}));
      end
      if (tx_valid && tx_ready) begin
        n_hs++;
        if (exp_ack.size() == 0) chk("unexpected_ack", 1'b0, 128'(tx_data), 128'(0));
        else begin
          mon_a = exp_ack.pop_front();
          chk("ack_byte", tx_data == mon_a, 128'(tx_data), 128'(mon_a));
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic put(input logic [7:0] b, input int gapmax);
    idle($urandom_range(gapmax, 0));
    rx_valid = 1'b1;
    rx_data  = b;
    idle(1);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic send_hdr(input logic [31:0] n, input int gapmax);
    for (int i = 0; i < 4; i++) put(n[8*i +: 8], gapmax);
  endtask

  task automatic do_reset();
    logic [PL_LEN_PROLD_INFO-1:0] rv;
    rv = '0;
    rv[PL_LEN_PROLD_INFO-1] = 1'b1;
    rst = 1'b1;
    idle(2);
    chk("reset_info", prold_info == rv, 128'(prold_info), 128'(rv));
    chk("reset_ctl", {tx_valid, tx_data, load_done, load_err} == 11'd0,
        128'({tx_valid, tx_data, load_done, load_err}), 128'(0));
    rst = 1'b0;
    exp_wr.delete();
    exp_ack.delete();
    n_ord = 0; n_done = 0; n_hs = 0; b2b = 0; ref_cyc = -100;
    idle(1);
  endtask

  task automatic load(input int n, input int gapmax, input int hold);
    int t;
    bit stable;
    for (int k = 0; k < n; k++) exp_wr.push_back({32'(4 * k), wbuf[k]});
    exp_ack.push_back(PL_ACK_BYTE);
    b2b = (gapmax == 0);
    send_hdr(32'(n), gapmax);
    // the 4th header byte was presented one cycle before the current label
    if (n == 0) ref_cyc = cyc - 1;
    for (int k = 0; k < n; k++)
      for (int i = 0; i < 4; i++) put(wbuf[k][8*i +: 8], gapmax);
    t = 0;
    while (!tx_valid && t < 50) begin idle(1); t++; end
    chk("ack_wait", tx_valid == 1'b1, 128'(t), 128'(50));
    stable = 1'b1;
    repeat (hold) begin
      idle(1);
      if (!(tx_valid && tx_data == PL_ACK_BYTE && !pi.mode)) stable = 1'b0;
    end
    if (hold > 0) chk("ack_hold", stable, 128'(stable), 128'(1));
    tx_ready = 1'b1;
    idle(1);
    tx_ready = 1'b0;
    idle(3);
    chk("post_ack", !tx_valid && !pi.mode && !load_err && !load_done,
        128'({tx_valid, pi.mode, load_err, load_done}), 128'(0));
    chk("counts", n_ord == n && n_done == 1 && n_hs == 1 && exp_wr.size() == 0 && exp_ack.size() == 0,
        128'({32'(n_ord), 32'(n_done), 32'(n_hs)}), 128'({32'(n), 32'd1, 32'd1}));
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    do_reset();

    wbuf[0] = 32'h0000_0013;
    wbuf[1] = 32'hDEAD_BEEF;
    load(2, 0, 0);

    do_reset();
    load(0, 0, 0);

    do_reset();
    send_hdr(32'(MEMW + 1), 0);
    repeat (8) put(8'($urandom), 1);
    idle(6);
    chk("err_state", load_err && pi.mode && !tx_valid,
        128'({load_err, pi.mode, tx_valid}), 128'({1'b1, 1'b1, 1'b0}));
    chk("err_silent", n_ord == 0 && n_done == 0, 128'({32'(n_ord), 32'(n_done)}), 128'(0));

    do_reset();
    for (int k = 0; k < 3; k++) wbuf[k] = $urandom;
    load(3, 5, 10);

    do_reset();
    for (int k = 0; k < MEMW; k++) wbuf[k] = $urandom;
    load(MEMW, 0, 0);

    do_reset();
    send_hdr(32'd5, 0);
    put(8'h12, 0);
    put(8'h34, 0);
    do_reset();
    wbuf[0] = $urandom;
    load(1, 2, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passes, total);
    $fatal(1);
  end

endmodule
